mmu_tile_sequencer: RTL
=======================

Name: mmu_tile_sequencer

Overview:
- Sequences one 4x4 output tile through the systolic MMU.
- Order of operations: clear the array, optionally preload bias, stream K operand beats as TRIGGER/TRIGGER_LAST commands, drain the skew pipeline with FORWARD commands, wait for mmu_busy to drop, return the four result rows over a valid/ready stream.
- Sits between the layer controller (start/done) and the MMU command/data ports; owns the MMU command bus exclusively.

Parameters:
- ACLEN, 8, MMU command width minus one (mmu_cmd is ACLEN+1 bits)
- DATA_WIDTH, 32, element width
- K_W, 16, width of the K-length field
- DRAIN_CYC, 6, FORWARD commands issued after TRIGGER_LAST (2*(4-1) skew)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  single-cycle start pulse; sampled only in IDLE
- k_len_i  in  K_W  inner-dimension length; latched at start
- bias_en_i  in  1  preload PEs with bias_i; latched at start
- bias_i  in  DATA_WIDTH*16  bias words, {row0 col0..3, row1 .., row3}; latched at start
- abort_i  in  1  abandon current tile
- op_valid_i  in  1  operand beat valid
- op_ready_o  out  1  operand beat accepted
- op_data_i  in  DATA_WIDTH*4  data for rows 0..3 (row0 in MSBs)
- op_weight_i  in  DATA_WIDTH*4  weights for columns 0..3 (col0 in MSBs)
- mmu_cmd_valid_o  out  1  MMU command valid
- mmu_cmd_o  out  ACLEN+1  MMU command code
- mmu_param_o  out  DATA_WIDTH*16  param_1..4 concatenated, param_1 in MSBs
- mmu_data_o  out  DATA_WIDTH*4  to data_1..4_in
- mmu_weight_o  out  DATA_WIDTH*4  to weight_1..4_in
- mmu_busy_i  in  1  MMU busy
- mmu_rdata_i  in  DATA_WIDTH*16  rdata_1..4_out concatenated, rdata_1 in MSBs
- res_valid_o  out  1  result row valid
- res_ready_i  in  1  result row accepted
- res_data_o  out  DATA_WIDTH*4  result row
- res_row_o  out  2  row index of res_data_o
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle tile-complete pulse
- err_o  out  1  one-cycle pulse on k_len_i==0 at start

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Any cycle with rst_i high forces this, including mid-tile. No MMU command is issued on reset; the next tile's CLR clears the array.
- All MMU-side outputs are registered. A command appears one cycle after the decision that produces it. mmu_cmd_valid_o is high for exactly one cycle per command.
- IDLE:
  - start_i with k_len_i==0: err_o pulses the next cycle; stay in IDLE.
  - start_i with k_len_i!=0: latch k_len_i, bias_en_i, bias_i; go to CLR.
- CLR: issue RESET (cmd 0), data/weight 0. Next state is PRELOAD if bias_en, else FEED.
- PRELOAD: issue SET_PE_VAL (cmd 5) with mmu_param_o = latched bias; go to FEED.
- FEED:
  - op_ready_o = 1.
  - Each op_valid_i&&op_ready_o handshake registers op_data/op_weight onto mmu_data_o/mmu_weight_o.
  - It issues TRIGGER (cmd 1), or TRIGGER_LAST (cmd 2) when k_cnt==k_len-1, and increments k_cnt.
  - Cycles without op_valid_i issue no command; the MMU skew registers hold.
  - After the TRIGGER_LAST handshake, go to DRAIN.
- DRAIN: issue FORWARD (cmd 8) with zero data/weight on DRAIN_CYC consecutive cycles; op_ready_o = 0; then go to WAIT.
- WAIT: no commands. First cycle with mmu_busy_i==0, move to RESULT, which occurs no earlier than the cycle after the final FORWARD.
- RESULT:
  - res_valid_o = 1; res_data_o = mmu_rdata_i slice for row res_row_o.
  - res_row_o advances 0→3 on each res_valid_o&&res_ready_i.
  - res_data_o must be stable while res_valid_o && !res_ready_i.
  - After the row-3 handshake, go to IDLE and pulse done_o in the same cycle busy_o falls.
- abort_i, any non-IDLE state:
  - Next cycle issue RESET (cmd 0), drop op_ready_o/res_valid_o, go to IDLE; no done_o.
  - abort_i coincident with the final handshake of a state: abort wins.
- start_i outside IDLE is ignored. k_cnt is K_W bits and never wraps, since k_len ≤ 2^K_W−1.
- Opcodes not in {0,1,2,5,8} are never issued.

Decomposition:
- Package mmu_pkg:
  - Command localparams RESET=0, TRIGGER=1, TRIGGER_LAST=2, SET_MUL_VAL=3, SET_ADD_VAL=4, SET_PE_VAL=5, SET_CONV_MODE=6, SET_FIX_MAC_MODE=7, FORWARD=8, TRIGGER_BN=17.
  - typedef enum logic [2:0] seq_state_t {IDLE, CLR, PRELOAD, FEED, DRAIN, WAIT, RESULT}.
- Single module, no sub-modules. The result row mux is inline.

Test Plan:
- start, k_len=4, bias_en=0, op_valid always 1 → exact command trace: RESET, TRIGGER×3, TRIGGER_LAST, FORWARD×6. Each operand appears on mmu_data_o one cycle after its handshake.
- bias_en=1, bias word row1/col2 = 0x0000_0005 → SET_PE_VAL issued directly after RESET, with that word at mmu_param_o bits [DATA_WIDTH*10-1 -: DATA_WIDTH]. Paired with MMU model, k_len=1, data=weight=1 → result row1 element col2 = 6.
- op_valid toggled 1,0,0,1,1 with k_len=3 → exactly 3 trigger commands, none in gap cycles; TRIGGER_LAST follows the 3rd handshake.
- mmu_busy held high 10 cycles after DRAIN; res_ready low 3 cycles on row 2 → no res_valid until busy falls; res_data/res_row stable during the stall; done_o one cycle after the row-3 handshake.
- k_len=0 start → err_o pulse, no MMU command, busy_o stays 0.
- abort during FEED at k_cnt=2 of 8 → RESET issued next cycle, IDLE, no done_o; a new start then runs cleanly. rst_i mid-DRAIN → all outputs 0 next cycle.

Source files
------------

// File: rtl/mmu_pkg.sv
// Command codes understood by the systolic MMU and the tile sequencer state encoding.
package mmu_pkg;

  localparam int unsigned RESET            = 0;
  localparam int unsigned TRIGGER          = 1;
  localparam int unsigned TRIGGER_LAST     = 2;
  localparam int unsigned SET_MUL_VAL      = 3;
  localparam int unsigned SET_ADD_VAL      = 4;
  localparam int unsigned SET_PE_VAL       = 5;
  localparam int unsigned SET_CONV_MODE    = 6;
  localparam int unsigned SET_FIX_MAC_MODE = 7;
  localparam int unsigned FORWARD          = 8;
  localparam int unsigned TRIGGER_BN       = 17;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    PRELOAD,
    FEED,
    DRAIN,
    WAIT,
    RESULT
  } seq_state_t;

endpackage

// File: rtl/mmu_tile_sequencer.sv
// Drives one 4x4 output tile through the MMU: clear, optional bias preload, K operand
// beats, skew drain, then hands the four accumulated rows back over a valid/ready stream.
module mmu_tile_sequencer
  import mmu_pkg::*;
#(
  parameter int ACLEN      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int K_W        = 16,
  parameter int DRAIN_CYC  = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [K_W-1:0]            k_len_i,
  input  logic                      bias_en_i,
  input  logic [DATA_WIDTH*16-1:0]  bias_i,
  input  logic                      abort_i,
  input  logic                      op_valid_i,
  output logic                      op_ready_o,
  input  logic [DATA_WIDTH*4-1:0]   op_data_i,
  input  logic [DATA_WIDTH*4-1:0]   op_weight_i,
  output logic                      mmu_cmd_valid_o,
  output logic [ACLEN:0]            mmu_cmd_o,
  output logic [DATA_WIDTH*16-1:0]  mmu_param_o,
  output logic [DATA_WIDTH*4-1:0]   mmu_data_o,
  output logic [DATA_WIDTH*4-1:0]   mmu_weight_o,
  input  logic                      mmu_busy_i,
  input  logic [DATA_WIDTH*16-1:0]  mmu_rdata_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [DATA_WIDTH*4-1:0]   res_data_o,
  output logic [1:0]                res_row_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int CMD_W = ACLEN + 1;
  localparam int ROW_W = DATA_WIDTH * 4;
  localparam int DC_W  = $clog2(DRAIN_CYC + 1);

  seq_state_t               state;
  logic [K_W-1:0]           k_len;
  logic [K_W-1:0]           k_cnt;
  logic                     bias_en;
  logic [DATA_WIDTH*16-1:0] bias;
  logic [DC_W-1:0]          drain_cnt;
  logic [1:0]               res_row;
  logic                     op_hs;
  logic                     res_hs;

  assign op_ready_o  = (state == FEED);
  assign res_valid_o = (state == RESULT);
  assign busy_o      = (state != IDLE);
  assign res_row_o   = res_row;
  assign op_hs       = op_valid_i && op_ready_o;
  assign res_hs      = res_valid_o && res_ready_i;

  // Row mux reads the MMU live; the MMU holds its outputs while idle, so the row stays stable during a stall.
  always_comb begin
    res_data_o = '0;
    if (state == RESULT) begin
      case (res_row)
        2'd0:    res_data_o = mmu_rdata_i[ROW_W*4-1 -: ROW_W];
        2'd1:    res_data_o = mmu_rdata_i[ROW_W*3-1 -: ROW_W];
        2'd2:    res_data_o = mmu_rdata_i[ROW_W*2-1 -: ROW_W];
        default: res_data_o = mmu_rdata_i[ROW_W*1-1 -: ROW_W];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) begin
      bias <= bias_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      k_len           <= '0;
      k_cnt           <= '0;
      bias_en         <= 1'b0;
      drain_cnt       <= '0;
      res_row         <= '0;
      mmu_cmd_valid_o <= 1'b0;
      mmu_cmd_o       <= '0;
      mmu_param_o     <= '0;
      mmu_data_o      <= '0;
      mmu_weight_o    <= '0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      mmu_cmd_valid_o <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      // Abort outranks every in-state transition, including a coincident final handshake.
      if (abort_i && state != IDLE) begin
        mmu_cmd_valid_o <= 1'b1;
        mmu_cmd_o       <= CMD_W'(RESET);
        mmu_param_o     <= '0;
        mmu_data_o      <= '0;
        mmu_weight_o    <= '0;
        k_cnt           <= '0;
        res_row         <= '0;
        state           <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (k_len_i == '0) begin
                err_o <= 1'b1;
              end else begin
                k_len     <= k_len_i;
                bias_en   <= bias_en_i;
                k_cnt     <= '0;
                drain_cnt <= '0;
                res_row   <= '0;
                state     <= CLR;
              end
            end
          end
          CLR: begin
            mmu_cmd_valid_o <= 1'b1;
            mmu_cmd_o       <= CMD_W'(RESET);
            mmu_param_o     <= '0;
            mmu_data_o      <= '0;
            mmu_weight_o    <= '0;
            state           <= bias_en ? PRELOAD : FEED;
          end
          PRELOAD: begin
            mmu_cmd_valid_o <= 1'b1;
            mmu_cmd_o       <= CMD_W'(SET_PE_VAL);
            mmu_param_o     <= bias;
            state           <= FEED;
          end
          FEED: begin
            if (op_hs) begin
              mmu_cmd_valid_o <= 1'b1;
              mmu_param_o     <= '0;
              mmu_data_o      <= op_data_i;
              mmu_weight_o    <= op_weight_i;
              k_cnt           <= k_cnt + 1'b1;
              if (k_cnt == k_len - 1'b1) begin
                mmu_cmd_o <= CMD_W'(TRIGGER_LAST);
                state     <= DRAIN;
              end else begin
                mmu_cmd_o <= CMD_W'(TRIGGER);
              end
            end
          end
          DRAIN: begin
            mmu_cmd_valid_o <= 1'b1;
            mmu_cmd_o       <= CMD_W'(FORWARD);
            mmu_data_o      <= '0;
            mmu_weight_o    <= '0;
            drain_cnt       <= drain_cnt + 1'b1;
            if (drain_cnt == DC_W'(DRAIN_CYC - 1)) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (!mmu_busy_i) begin
              state <= RESULT;
            end
          end
          RESULT: begin
            if (res_hs) begin
              res_row <= res_row + 2'd1;
              if (res_row == 2'd3) begin
                done_o <= 1'b1;
                state  <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
